// File: rtl/lap_capture.sv
// Lap capture: samples the stopwatch count on each lap, computes the split since the
// previous accepted lap (modulo MAX+1) and queues {abs, split} in a small FWFT FIFO.
module lap_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [DATA_WIDTH-1:0]      count,
  input  logic                       lap,
  input  logic                       lap_ready,
  output logic                       lap_valid,
  output logic [DATA_WIDTH-1:0]      lap_abs,
  output logic [DATA_WIDTH-1:0]      lap_split,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0]         LEVEL_FULL = LW'(DEPTH);
  localparam logic [DATA_WIDTH:0]   MODULUS    = (DATA_WIDTH + 1)'(MAX + 1);

  logic [DATA_WIDTH-1:0] abs_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] split_mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] prev;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH:0]   split_x;
  logic [DATA_WIDTH-1:0] split;
  logic                  unused_split_msb;

  // Handshake: an entry transfers on any edge where lap_valid && lap_ready. lap_valid
  // is derived only from registered occupancy, never from lap_ready; the consumer may
  // hold lap_ready high indefinitely. The head entry is stable while it is not popped.
  assign lap_valid = (level != '0);
  assign full      = (level == LEVEL_FULL);
  assign lap_abs   = abs_mem[rd_ptr];
  assign lap_split = split_mem[rd_ptr];

  assign pop  = lap_valid && lap_ready;
  assign push = lap && (!full || pop);

  // Wide arithmetic so count + (MAX+1) cannot wrap before prev is subtracted.
  always_comb begin
    split_x = '0;
    if (count >= prev) begin
      split_x = {1'b0, count} - {1'b0, prev};
    end else begin
      split_x = {1'b0, count} + MODULUS - {1'b0, prev};
    end
  end

  assign split            = split_x[DATA_WIDTH-1:0];
  assign unused_split_msb = split_x[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      prev     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        abs_mem[i]   <= '0;
        split_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        abs_mem[wr_ptr]   <= count;
        split_mem[wr_ptr] <= split;
        wr_ptr            <= wr_ptr + AW'(1);
        prev              <= count;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
      // A lap that could not be pushed was dropped; prev stays so the next split spans it.
      if (lap && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lap_capture.sv
// Directed bench for lap_capture: a table of per-cycle inputs and expected outputs,
// followed by a hand-written streaming sequence checked against an expected queue.
module tb_lap_capture;

  localparam int W     = 16;
  localparam int MAX   = 99;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          clear;
  logic [W-1:0]  count;
  logic          lap;
  logic          lap_ready;
  logic          lap_valid;
  logic [W-1:0]  lap_abs;
  logic [W-1:0]  lap_split;
  logic [LW-1:0] level;
  logic          full;
  logic          overflow;

  int pass_cnt;
  int total_cnt;

  lap_capture #(.DATA_WIDTH(W), .MAX(MAX), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .count     (count),
    .lap       (lap),
    .lap_ready (lap_ready),
    .lap_valid (lap_valid),
    .lap_abs   (lap_abs),
    .lap_split (lap_split),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          clr;
    logic [W-1:0]  cnt;
    logic          lp;
    logic          rdy;
    logic          e_valid;
    logic [W-1:0]  e_abs;
    logic [W-1:0]  e_split;
    logic [LW-1:0] e_level;
    logic          e_full;
    logic          e_ovf;
    logic          chk_data;
  } vec_t;

  vec_t vecs[$];
  logic [2*W-1:0] exp_q[$];

  task automatic add(input logic rst, input logic clr, input int cnt, input logic lp,
                     input logic rdy, input logic ev, input int ea, input int es,
                     input int el, input logic ef, input logic eo, input logic cd);
    vec_t v;
    v.rst = rst; v.clr = clr; v.cnt = W'(cnt); v.lp = lp; v.rdy = rdy;
    v.e_valid = ev; v.e_abs = W'(ea); v.e_split = W'(es); v.e_level = LW'(el);
    v.e_full = ef; v.e_ovf = eo; v.chk_data = cd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present inputs, advance one edge, sample 1 time unit later
  task automatic drive(input logic rst, input logic clr, input logic [W-1:0] cnt,
                       input logic lp, input logic rdy);
    reset = rst; clear = clr; count = cnt; lap = lp; lap_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s_queue: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_abs"}, 32'(lap_abs), 32'(e[2*W-1:W]));
      check({tag, "_split"}, 32'(lap_split), 32'(e[W-1:0]));
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b1; clear = 1'b0; count = '0; lap = 1'b0; lap_ready = 1'b0;

    //    rst clr cnt lap rdy | valid abs split lvl full ovf chkdata
    add(1, 0,  0, 0, 0,  0,  0,  0, 0, 0, 0, 1);  // reset state
    add(1, 0,  0, 1, 1,  0,  0,  0, 0, 0, 0, 1);  // reset wins over lap
    // basic capture
    add(0, 0, 25, 1, 0,  1, 25, 25, 1, 0, 0, 1);
    add(0, 0,  0, 0, 1,  0,  0,  0, 0, 0, 0, 0);
    // consecutive laps and drain
    add(0, 1,  0, 0, 0,  0,  0,  0, 0, 0, 0, 1);
    add(0, 0, 10, 1, 0,  1, 10, 10, 1, 0, 0, 1);
    add(0, 0, 30, 1, 0,  1, 10, 10, 2, 0, 0, 1);
    add(0, 0, 75, 1, 0,  1, 10, 10, 3, 0, 0, 1);
    add(0, 0,  0, 0, 1,  1, 30, 20, 2, 0, 0, 1);
    add(0, 0,  0, 0, 1,  1, 75, 45, 1, 0, 0, 1);
    add(0, 0,  0, 0, 1,  0,  0,  0, 0, 0, 0, 0);
    // wrap-around split (prev=75) and repeated lap
    add(0, 0, 90, 1, 0,  1, 90, 15, 1, 0, 0, 1);
    add(0, 0,  5, 1, 0,  1, 90, 15, 2, 0, 0, 1);
    add(0, 0,  5, 1, 1,  1,  5, 15, 2, 0, 0, 1);
    add(0, 0,  0, 0, 1,  1,  5,  0, 1, 0, 0, 1);
    add(0, 0,  0, 0, 1,  0,  0,  0, 0, 0, 0, 0);
    // full / overflow
    add(0, 1,  0, 0, 0,  0,  0,  0, 0, 0, 0, 1);
    add(0, 0, 10, 1, 0,  1, 10, 10, 1, 0, 0, 1);
    add(0, 0, 20, 1, 0,  1, 10, 10, 2, 0, 0, 1);
    add(0, 0, 30, 1, 0,  1, 10, 10, 3, 0, 0, 1);
    add(0, 0, 40, 1, 0,  1, 10, 10, 4, 1, 0, 1);
    add(0, 0, 50, 1, 0,  1, 10, 10, 4, 1, 1, 1);
    add(0, 0,  0, 0, 1,  1, 20, 10, 3, 0, 1, 1);
    add(0, 0, 70, 1, 0,  1, 20, 10, 4, 1, 1, 1);
    add(0, 0,  0, 0, 1,  1, 30, 10, 3, 0, 1, 1);
    add(0, 0,  0, 0, 1,  1, 40, 10, 2, 0, 1, 1);
    add(0, 0,  0, 0, 1,  1, 70, 30, 1, 0, 1, 1);
    add(0, 0,  0, 0, 1,  0,  0,  0, 0, 0, 1, 0);
    // full with simultaneous push and pop
    add(0, 1,  0, 0, 0,  0,  0,  0, 0, 0, 0, 1);
    add(0, 0, 10, 1, 0,  1, 10, 10, 1, 0, 0, 1);
    add(0, 0, 20, 1, 0,  1, 10, 10, 2, 0, 0, 1);
    add(0, 0, 30, 1, 0,  1, 10, 10, 3, 0, 0, 1);
    add(0, 0, 40, 1, 0,  1, 10, 10, 4, 1, 0, 1);
    add(0, 0, 60, 1, 1,  1, 20, 10, 4, 1, 0, 1);
    add(0, 0,  0, 0, 1,  1, 30, 10, 3, 0, 0, 1);
    add(0, 0,  0, 0, 1,  1, 40, 10, 2, 0, 0, 1);
    add(0, 0,  0, 0, 1,  1, 60, 20, 1, 0, 0, 1);
    add(0, 0,  0, 0, 1,  0,  0,  0, 0, 0, 0, 0);
    // clear mid-operation (prev=60, so first split wraps)
    add(0, 0,  1, 1, 0,  1,  1, 41, 1, 0, 0, 1);
    add(0, 0,  2, 1, 0,  1,  1, 41, 2, 0, 0, 1);
    add(0, 0,  3, 1, 0,  1,  1, 41, 3, 0, 0, 1);
    add(0, 1, 50, 1, 1,  0,  0,  0, 0, 0, 0, 1);
    add(0, 0, 12, 1, 0,  1, 12, 12, 1, 0, 0, 1);
    // reset mid-operation, with overflow set
    add(0, 0, 20, 1, 0,  1, 12, 12, 2, 0, 0, 1);
    add(0, 0, 30, 1, 0,  1, 12, 12, 3, 0, 0, 1);
    add(0, 0, 40, 1, 0,  1, 12, 12, 4, 1, 0, 1);
    add(0, 0, 50, 1, 0,  1, 12, 12, 4, 1, 1, 1);
    add(1, 0, 50, 1, 1,  0,  0,  0, 0, 0, 0, 1);
    add(0, 0, 12, 1, 0,  1, 12, 12, 1, 0, 0, 1);
    add(0, 0,  0, 0, 1,  0,  0,  0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].cnt, vecs[i].lp, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), 32'(lap_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_abs", i), 32'(lap_abs), 32'(vecs[i].e_abs));
        check($sformatf("v%0d_split", i), 32'(lap_split), 32'(vecs[i].e_split));
      end
    end

    // lap_ready held high: single entry visible one cycle, then one push + one pop per cycle
    exp_q.push_back({W'(7),  W'(95)});   // prev=12 -> 7 + 100 - 12
    exp_q.push_back({W'(20), W'(13)});
    exp_q.push_back({W'(40), W'(20)});
    exp_q.push_back({W'(60), W'(20)});

    drive(0, 0, W'(7), 1, 1);
    check("s_single_valid", 32'(lap_valid), 32'd1);
    check("s_single_level", 32'(level), 32'd1);
    check_head("s_single");
    drive(0, 0, W'(0), 0, 1);
    check("s_single_gone", 32'(lap_valid), 32'd0);
    check("s_single_level0", 32'(level), 32'd0);

    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, W'(20 * k), 1, 1);
      check($sformatf("s_stream%0d_valid", k), 32'(lap_valid), 32'd1);
      check($sformatf("s_stream%0d_level", k), 32'(level), 32'd1);
      check_head($sformatf("s_stream%0d", k));
    end
    drive(0, 0, W'(0), 0, 1);
    check("s_stream_end_valid", 32'(lap_valid), 32'd0);
    check("s_stream_end_ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
